// File: rtl/uart_rx_pkg.sv
// Shared UART constants: oversampling ratio, mid-bit tick count and the
// derived counter width, plus a small helper for "last tick of a period".
package uart_rx_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned MID_TICK   = 8;
   localparam int unsigned TICK_W     = $clog2(OVERSAMPLE);
   localparam int unsigned DATA_BITS  = 8;

   // True when a tick counter holds the final count of a period of 'period' ticks
   function automatic logic is_last_tick(input logic [TICK_W-1:0] cnt,
                                         input int unsigned       period);
      return cnt == TICK_W'(period - 1);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous RxD pin. Resets to the idle
// (high) line level so no false start bit is seen coming out of reset.
module uart_sync
   import uart_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   // Shift the raw pin into the chain, oldest sample at the top
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
   end

   // Synchronizer flops, reset to the idle-high level
   always_ff @(posedge clk) begin
      if (rst) sync_q <= '1;
      else     sync_q <= sync_d;
   end

   assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, 16x oversampling driven by uart_tick. Detects the start
// edge, confirms it at mid start bit, samples each data bit at its centre and
// checks the stop bit. Delivers bytes through a data_ready/rx_ack handshake
// with sticky overrun and a one-cycle frame_error pulse.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_tick,
   input  logic       RxD,
   input  logic       rx_ack,
   output logic [7:0] RxD_data,
   output logic       data_ready,
   output logic       frame_error,
   output logic       overrun
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_RECOVER
   } state_t;

   logic                 rxd_s;
   state_t               state_q,  state_d;
   logic [TICK_W-1:0]    cnt_q,    cnt_d;
   logic [2:0]           idx_q,    idx_d;
   logic [DATA_BITS-1:0] shreg_q,  shreg_d;
   logic [DATA_BITS-1:0] data_q,   data_d;
   logic                 rdy_q,    rdy_d;
   logic                 ferr_q,   ferr_d;
   logic                 ovr_q,    ovr_d;
   logic                 load;

   uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (RxD),
      .dout (rxd_s)
   );

   // Frame FSM, tick/bit counters and the byte handshake outputs
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      load    = 1'b0;
      ferr_d  = 1'b0;

      if (uart_tick) begin
         case (state_q)
            ST_IDLE: begin
               if (!rxd_s) begin
                  state_d = ST_START;
                  cnt_d   = '0;
               end
            end
            ST_START: begin
               cnt_d = cnt_q + 1'b1;
               if (is_last_tick(cnt_q, MID_TICK)) begin
                  if (!rxd_s) begin
                     state_d = ST_DATA;
                     cnt_d   = '0;
                     idx_d   = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_DATA: begin
               cnt_d = cnt_q + 1'b1;
               if (is_last_tick(cnt_q, OVERSAMPLE)) begin
                  shreg_d[idx_q] = rxd_s;
                  cnt_d          = '0;
                  if (idx_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
                  else                           idx_d   = idx_q + 1'b1;
               end
            end
            ST_STOP: begin
               cnt_d = cnt_q + 1'b1;
               if (is_last_tick(cnt_q, OVERSAMPLE)) begin
                  cnt_d = '0;
                  if (rxd_s) begin
                     load    = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = ST_RECOVER;
                  end
               end
            end
            ST_RECOVER: begin
               // Wait out a break so a held-low line reports only once
               if (rxd_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // A load beats a simultaneous acknowledge; ack alone clears both flags
      data_d = load ? shreg_q : data_q;
      if (load) begin
         rdy_d = 1'b1;
         ovr_d = rx_ack ? 1'b0 : (ovr_q | rdy_q);
      end else if (rx_ack) begin
         rdy_d = 1'b0;
         ovr_d = 1'b0;
      end else begin
         rdy_d = rdy_q;
         ovr_d = ovr_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         data_q  <= '0;
         rdy_q   <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         rdy_q   <= rdy_d;
         ferr_q  <= ferr_d;
         ovr_q   <= ovr_d;
      end
   end

   assign RxD_data    = data_q;
   assign data_ready  = rdy_q;
   assign frame_error = ferr_q;
   assign overrun     = ovr_q;

endmodule
